// File: rtl/prod_accum.sv
`default_nettype none
// ============================================================================
// prod_accum: sums frames of LEN 7-bit products over valid/ready handshakes,
// presenting each frame total with a sticky accumulator-wrap flag.
// Revision: 1.0
// ============================================================================
module prod_accum #(
  parameter int LEN   = 4,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       prod_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] sum_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf_out,
  output logic [7:0]       cnt_out
);

  localparam int         SUM_W = ACC_W + 1;
  localparam logic [7:0] LAST  = 8'(LEN - 1);

  localparam logic [0:0] S_ACC  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]       state_q,   state_d;
  logic [ACC_W-1:0] acc_q,     acc_d;
  logic [7:0]       cnt_q,     cnt_d;
  logic             ovf_q,     ovf_d;
  logic [ACC_W-1:0] sum_q,     sum_d;
  logic             ovf_out_q, ovf_out_d;

  logic [SUM_W-1:0] add_ext;
  logic             take;

  // Zero-extended add one bit wider than the accumulator; the MSB is the carry.
  assign add_ext  = {1'b0, acc_q} + SUM_W'(prod_in);
  assign in_ready = (state_q == S_ACC) && !clr;
  assign take     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      S_ACC: begin
        if (clr) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (take) begin
          if (cnt_q == LAST) begin
            // Running state is frozen in HOLD so cnt_out reads LEN-1.
            sum_d     = add_ext[ACC_W-1:0];
            ovf_out_d = ovf_q | add_ext[ACC_W];
            state_d   = S_HOLD;
          end else begin
            acc_d = add_ext[ACC_W-1:0];
            cnt_d = cnt_q + 8'd1;
            ovf_d = ovf_q | add_ext[ACC_W];
          end
        end
      end
      default: begin
        if (out_ready) begin
          state_d = S_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign sum_out   = sum_q;
  assign ovf_out   = ovf_out_q;
  assign out_valid = (state_q == S_HOLD);
  assign cnt_out   = cnt_q;

endmodule
`default_nettype wire
